// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_DIV_EN to build the divider; without it, ops 100-111 finish at once flagged illegal.
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    // Handshake: start is sampled only in IDLE; busy covers every cycle from the one after
    // acceptance through the done cycle; done is a one-cycle pulse with result valid in it,
    // and result then holds until the next operation completes.

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   b_q;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic              illegal_q;
    logic [XLEN-1:0]   result_q;

    logic              a_signed;
    logic              b_signed;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              bypass;
    logic              last_iter;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   res_fix;

`ifdef MULDIV_DIV_EN
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] div_nxt;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
`endif

    // Operand signedness by funct3, then magnitudes for the unsigned core.
    always_comb begin
        if (op[2]) begin
            a_signed = !op[0];
            b_signed = !op[0];
        end else begin
            a_signed = (op[1:0] != 2'b11);
            b_signed = !op[1];
        end
        neg_a = a_signed && rs1[XLEN-1];
        neg_b = b_signed && rs2[XLEN-1];
        mag_a = neg_a ? (~rs1 + 1'b1) : rs1;
        mag_b = neg_b ? (~rs2 + 1'b1) : rs2;
    end

`ifdef MULDIV_DIV_EN
    always_comb begin
        div_zero = (rs2 == '0);
        div_ovf  = !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
        bypass   = op[2] && (div_zero || div_ovf);
    end
`else
    always_comb begin
        bypass = op[2];
    end
`endif

    assign last_iter = (state == CALC) && (cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = bypass ? FIN : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Low half holds the multiplier / dividend and shifts out as the step proceeds.
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        mul_nxt = {mul_sum, acc[XLEN-1:1]};
    end

`ifdef MULDIV_DIV_EN
    always_comb begin
        rem_sh = acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, b_q};
        if (diff[XLEN]) begin
            div_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            div_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
        acc_nxt = op_q[2] ? div_nxt : mul_nxt;
    end
`else
    always_comb begin
        acc_nxt = mul_nxt;
    end
`endif

    // Sign fix-up applied to the value produced by the final iteration.
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_nxt : acc_nxt;
        mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix  = neg_a_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        res_fix  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix) : mul_res;
`else
        res_fix  = op_q[2] ? '0 : mul_res;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        neg_a_q   <= neg_a;
                        neg_b_q   <= neg_b;
                        acc       <= {{XLEN{1'b0}}, mag_a};
                        b_q       <= mag_b;
                        cnt       <= '0;
                        illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
                        if (op[2] && div_zero) begin
                            result_q <= op[1] ? rs1 : '1;
                        end else if (op[2] && div_ovf) begin
                            result_q <= op[1] ? '0 : rs1;
                        end
`else
                        if (op[2]) begin
                            result_q  <= '0;
                            illegal_q <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        result_q <= res_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign illegal = done && illegal_q;
    assign result  = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed and randomized bench for riscv_muldiv_unit against a plain-arithmetic reference model.
// Expectations for ops 100-111 follow whether MULDIV_DIV_EN is defined for the build.
module tb_riscv_muldiv_unit;

    localparam int XLEN = 32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs1     (rs1),
        .rs2     (rs2),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .illegal (illegal)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // reference model
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            3'd7: begin
                if (b == 32'd0) return a;
                return a % b;
            end
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        if (o[2] && (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return XLEN + 1;
`else
        if (o[2] || a === 32'hx || b === 32'hx) return 1;
        return XLEN + 1;
`endif
    endfunction

    function automatic logic ref_ill(input logic [2:0] o);
`ifdef MULDIV_DIV_EN
        if (o === 3'bx) return 1'b1;
        return 1'b0;
`else
        return o[2];
`endif
    endfunction

    function automatic logic [31:0] pick_operand(input int k);
        case (k)
            0:       return $urandom;
            1:       return 32'd0;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'd0 - 32'($urandom_range(1, 20));
        endcase
    endfunction

    // driver: one operation, inputs scrambled after acceptance, a start poked while busy
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit fin_poke);
        int          cyc;
        logic [31:0] expv;
        exp_q.push_back(ref_res(o, a, b));
        @(negedge clk);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
        check("busy_after_accept", busy, 1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            start = (cyc == 3);
            if (cyc == 3) begin
                op  = 3'($urandom);
                rs1 = $urandom;
                rs2 = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        expv  = exp_q.pop_front();
        check("latency", cyc, ref_lat(o, a, b));
        check("result", result, expv);
        check("illegal", illegal, ref_ill(o));
        if (fin_poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("fin_start_ignored", busy, 0);
            check("done_single_pulse", done, 0);
            check("result_held", result, expv);
        end
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        rs1   = 32'd0;
        rs2   = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_illegal", illegal, 0);
        rst_n = 1'b1;

        // directed cases, including back-to-back starts (fin_poke = 0)
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        check("mul_7_m3", result, 32'hFFFF_FFEB);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(3'd4, 32'hFFFF_FFEC, 32'd6, 1'b1);
        do_op(3'd6, 32'hFFFF_FFEC, 32'd6, 1'b0);
        do_op(3'd5, 32'd5, 32'd0, 1'b1);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op(3'd7, 32'd5, 32'd0, 1'b0);
        do_op(3'd4, 32'd7, 32'd0, 1'b1);
        do_op(3'd7, 32'd100, 32'd7, 1'b1);

        // randomized operations over mixed operand classes
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand($urandom_range(0, 5)),
                  pick_operand($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        op    = 3'd0;
        rs1   = 32'd123;
        rs2   = 32'd456;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_result_after", result, 0);
        do_op(3'd0, 32'd3, 32'd4, 1'b1);
        check("mul_3_4", result, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
